ram64_fifo: RTL
===============

RAM64_FIFO -- requirements
Module: ram64_fifo

Interface
REQ-001 The block SHALL have no parameters; depth is fixed at 64 words of RAM storage plus 1 output register, and width at 16 bits.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 in_data_i  input  16  write word.
REQ-005 in_valid_i  input  1  write request.
REQ-006 in_ready_o  output  1  write accept; a word is taken on an edge where in_valid_i=1 and in_ready_o=1.
REQ-007 out_data_o  output  16  head-of-queue word, registered.
REQ-008 out_valid_o  output  1  out_data_o holds a valid word.
REQ-009 out_ready_i  input  1  consumer accept; a word is popped on an edge where out_valid_o=1 and out_ready_i=1.
REQ-010 level_o  output  7  total words held: RAM words plus out_valid_o, range 0..65.
REQ-011 full_o  output  1  RAM storage holds 64 words.
REQ-012 empty_o  output  1  level_o = 0.

Function
REQ-013 The block SHALL store words in one instance of RAM64: in_i = in_data_i, address_i = the current pointer, and out_o feeding the output register.
REQ-014 The block SHALL keep a 6-bit wr_ptr, a 6-bit rd_ptr and a 7-bit mem_count (0..64); both pointers SHALL wrap from 63 to 0 with no special handling.
REQ-015 RAM64 is single-ported, so each cycle SHALL be exactly one of READ, WRITE or IDLE, decided combinationally.
REQ-016 READ SHALL occur when mem_count != 0 and (out_valid_o = 0 or out_ready_i = 1); READ has priority over WRITE.
REQ-017 In a READ cycle: address_i = rd_ptr, load_i = 0.
REQ-018 On the READ edge: out_data_o <= RAM64 out_o, out_valid_o <= 1, rd_ptr += 1, mem_count -= 1.
REQ-019 in_ready_o SHALL be 1 only when mem_count < 64 and the cycle is not READ.
REQ-020 WRITE occurs when in_valid_i = 1 and in_ready_o = 1.
REQ-021 In a WRITE cycle: address_i = wr_ptr, load_i = 1.
REQ-022 On the WRITE edge: wr_ptr += 1, mem_count += 1.
REQ-023 In all non-WRITE cycles, load_i SHALL be 0.
REQ-024 A pop without a READ in the same cycle SHALL clear out_valid_o; a pop with a READ SHALL reload out_data_o, so back-to-back output is possible.
REQ-025 out_data_o SHALL hold its value while out_valid_o = 1 and out_ready_i = 0.
REQ-026 Latency: a word accepted into an empty block at edge E SHALL appear with out_valid_o = 1 after edge E+1.
REQ-027 Sustained throughput with both sides active: at least one word per 2 cycles.
REQ-028 Full boundary: with mem_count = 64, in_ready_o = 0 and in_valid_i SHALL be ignored; no RAM write occurs.
REQ-029 Empty boundary: with mem_count = 0, no READ occurs; out_ready_i with out_valid_o = 0 SHALL have no effect.
REQ-030 level_o, full_o and empty_o SHALL be combinational from registered state only.

Reset
REQ-031 When rst_i = 1 at an edge: wr_ptr, rd_ptr and mem_count SHALL be 0, out_valid_o SHALL be 0 and out_data_o SHALL be 16'h0000; this is the value of every output afterwards (in_ready_o = 1, level_o = 0, full_o = 0, empty_o = 1).
REQ-032 While rst_i = 1, load_i SHALL be forced to 0 and in_ready_o to 0.
REQ-033 RAM contents are not cleared; reset mid-operation SHALL discard all queued words logically, and no stale word SHALL ever be presented afterwards.

Verification
REQ-034 Reset then idle -> out_valid_o = 0, level_o = 0, empty_o = 1, in_ready_o = 1, out_data_o = 16'h0000.
REQ-035 Push 16'hBEEF into empty block at edge E with out_ready_i = 0 -> out_valid_o = 1 and out_data_o = 16'hBEEF after E+1, level_o = 1; the word holds for 10 cycles until popped.
REQ-036 With out_ready_i = 0, push 0..70 continuously -> exactly 65 words accepted, full_o = 1, level_o = 65, in_ready_o = 0; then drain -> output sequence 0..64 in order, then empty_o = 1.
REQ-037 Pointer wrap: push and pop 200 sequential words with random valid/ready -> output order identical to input, no loss or duplication, level_o never exceeds 65.
REQ-038 Simultaneous: in_valid_i = 1, out_ready_i = 1, mem_count = 3 -> READ wins the cycle, in_ready_o = 0, no write occurs, out_data_o advances to the next word.
REQ-039 Assert rst_i with 20 words queued, then push 16'h1234 -> first output after reset is 16'h1234, level_o = 1.

Source files
------------

// File: rtl/ram64_fifo.sv
// 64-word x 16-bit FIFO built on a single-ported RAM64 plus one registered output stage.
// Each cycle the RAM port is given to exactly one READ, WRITE or IDLE operation.

module RAM64 (
    input  logic        clk_i,
    input  logic [15:0] in_i,
    input  logic [5:0]  address_i,
    input  logic        load_i,
    output logic [15:0] out_o
);

    logic [15:0] mem [0:63];

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            mem[address_i] <= in_i;
        end
    end

    // Asynchronous read so the output register can capture the word on the READ edge.
    assign out_o = mem[address_i];

endmodule

module ram64_fifo (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [15:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [6:0]  level_o,
    output logic        full_o,
    output logic        empty_o
);

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_READ  = 2'd1,
        CYC_WRITE = 2'd2
    } cycle_kind_t;

    logic [5:0]  wr_ptr;
    logic [5:0]  rd_ptr;
    logic [6:0]  mem_count;
    logic [5:0]  ram_address;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        read_wanted;
    logic        pop;
    cycle_kind_t cycle_kind;

    RAM64 u_ram (
        .clk_i     (clk_i),
        .in_i      (in_data_i),
        .address_i (ram_address),
        .load_i    (ram_load),
        .out_o     (ram_out)
    );

    // Refilling the output stage always beats accepting a new word for the RAM port.
    always_comb begin
        read_wanted = !rst_i && (mem_count != 7'd0) && (!out_valid_o || out_ready_i);
        in_ready_o  = !rst_i && (mem_count < 7'd64) && !read_wanted;
        pop         = out_valid_o && out_ready_i;
        cycle_kind  = CYC_IDLE;
        if (read_wanted) begin
            cycle_kind = CYC_READ;
        end else if (in_valid_i && in_ready_o) begin
            cycle_kind = CYC_WRITE;
        end
        ram_load    = (cycle_kind == CYC_WRITE);
        ram_address = (cycle_kind == CYC_READ) ? rd_ptr : wr_ptr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= 6'd0;
            rd_ptr      <= 6'd0;
            mem_count   <= 7'd0;
            out_valid_o <= 1'b0;
            out_data_o  <= 16'h0000;
        end else begin
            case (cycle_kind)
                CYC_READ: begin
                    out_data_o  <= ram_out;
                    out_valid_o <= 1'b1;
                    rd_ptr      <= rd_ptr + 6'd1;
                    mem_count   <= mem_count - 7'd1;
                end
                CYC_WRITE: begin
                    wr_ptr    <= wr_ptr + 6'd1;
                    mem_count <= mem_count + 7'd1;
                    if (pop) begin
                        out_valid_o <= 1'b0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_valid_o <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign level_o = mem_count + {6'd0, out_valid_o};
    assign full_o  = (mem_count == 7'd64);
    assign empty_o = (level_o == 7'd0);

endmodule
